vga_rx_capture: RTL

- Receive end of the VGA timing generator: consumes hsync, vsync and the 3-bit RGB stream on the same pixel clock.
- Recovers pixel X/Y coordinates and emits a qualified pixel stream for a frame-buffer writer or checker.
- Measures line length, flags malformed lines and frames, and reports lock.
- Sits downstream of the VGA generator, in loopback test setups and in the capture path.

---
 rtl/vga_rx_capture.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_capture.sv
// Recovers pixel coordinates from a VGA hsync/vsync/RGB stream; measures line length, flags malformed lines/frames, reports lock.
// Latency: pixel outputs appear 2 clk after iColor is presented; error/lock outputs 2 clk after the offending sync edge.
// Backpressure: none; free-running pixel-rate stream with no ready input.
module vga_rx_capture #(
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iHSync,
    input  logic        iVSync,
    input  logic [2:0]  iColor,
    output logic [2:0]  oPixel,
    output logic        oPixValid,
    output logic [9:0]  oPixX,
    output logic [9:0]  oPixY,
    output logic        oFrameStart,
    output logic [10:0] oLineClks,
    output logic        oLineErr,
    output logic        oFrameErr,
    output logic        oLocked
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        HBP,
        ACTIVE,
        HTAIL,
        VWAIT,
        VSYNC
    } state_t;

    // H_BP >= 1 and H_BP + H_ACTIVE <= 1023 are assumed. With H_BP == 1 the
    // first active sample follows the hs_end cycle directly, so HBP is skipped.
    localparam logic [9:0]  HBP_LAST   = 10'(H_BP - 1);
    localparam logic [9:0]  HACT_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  VACT       = 10'(V_ACTIVE);
    localparam logic [10:0] LCLK_MAX   = 11'd2047;
    localparam state_t      LINE_ENTRY = (H_BP > 1) ? HBP : ACTIVE;
    localparam logic [9:0]  ENTRY_CNT  = (H_BP > 1) ? 10'd1 : 10'd0;

    logic       hs_s1, hs_s2, vs_s1, vs_s2;
    logic [2:0] color_s1;
    logic       hs_end, hs_start, vs_end, vs_start;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] line_q, line_d;
    logic [9:0] line_nxt;
    logic [9:0] lines_done;
    logic       frame_bad_q, frame_bad_d;
    logic       pix_vld_d, fs_d, line_err_d, frame_err_d;
    logic       lock_set, lock_clr;

    logic [10:0] lclk_q;
    logic        lclk_seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1    <= 1'b1;
            hs_s2    <= 1'b1;
            vs_s1    <= 1'b1;
            vs_s2    <= 1'b1;
            color_s1 <= '0;
        end else begin
            hs_s1    <= iHSync;
            hs_s2    <= hs_s1;
            vs_s1    <= iVSync;
            vs_s2    <= vs_s1;
            color_s1 <= iColor;
        end
    end

    assign hs_end   =  hs_s1 & ~hs_s2;
    assign hs_start = ~hs_s1 &  hs_s2;
    assign vs_end   =  vs_s1 & ~vs_s2;
    assign vs_start = ~vs_s1 &  vs_s2;

    assign line_nxt = 10'(line_q + 10'd1);

    // Lines finished so far in the current frame; an aborted line still counts.
    always_comb begin
        lines_done = '0;
        case (state_q)
            HBP, ACTIVE: lines_done = line_q;
            HTAIL:       lines_done = line_nxt;
            VWAIT:       lines_done = VACT;
            default:     lines_done = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        frame_bad_d = frame_bad_q;
        pix_vld_d   = 1'b0;
        fs_d        = 1'b0;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        lock_set    = 1'b0;
        lock_clr    = 1'b0;

        if (vs_start && state_q != IDLE && state_q != VSYNC) begin
            state_d = VSYNC;
            if (lines_done != VACT) begin
                frame_err_d = 1'b1;
                lock_clr    = 1'b1;
            end else if (!frame_bad_q) begin
                lock_set = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (vs_end) begin
                        state_d     = WAIT_LINE;
                        frame_bad_d = 1'b0;
                    end
                end
                WAIT_LINE: begin
                    if (hs_end) begin
                        line_d  = '0;
                        state_d = LINE_ENTRY;
                        cnt_d   = ENTRY_CNT;
                    end
                end
                HBP: begin
                    if (hs_start) begin
                        state_d     = HTAIL;
                        line_err_d  = 1'b1;
                        lock_clr    = 1'b1;
                        frame_bad_d = 1'b1;
                    end else if (cnt_q == HBP_LAST) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = 10'(cnt_q + 10'd1);
                    end
                end
                ACTIVE: begin
                    if (hs_start) begin
                        state_d     = HTAIL;
                        line_err_d  = 1'b1;
                        lock_clr    = 1'b1;
                        frame_bad_d = 1'b1;
                    end else begin
                        pix_vld_d = 1'b1;
                        fs_d      = (cnt_q == '0) && (line_q == '0);
                        if (cnt_q == HACT_LAST) begin
                            state_d = HTAIL;
                        end else begin
                            cnt_d = 10'(cnt_q + 10'd1);
                        end
                    end
                end
                HTAIL: begin
                    // Lines beyond V_ACTIVE are parked in VWAIT and ignored.
                    if (hs_end) begin
                        if (line_nxt < VACT) begin
                            line_d  = line_nxt;
                            state_d = LINE_ENTRY;
                            cnt_d   = ENTRY_CNT;
                        end else begin
                            state_d = VWAIT;
                        end
                    end
                end
                VSYNC: begin
                    if (vs_end) begin
                        state_d     = WAIT_LINE;
                        frame_bad_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            frame_bad_q <= 1'b0;
            oPixel      <= '0;
            oPixValid   <= 1'b0;
            oPixX       <= '0;
            oPixY       <= '0;
            oFrameStart <= 1'b0;
            oLineErr    <= 1'b0;
            oFrameErr   <= 1'b0;
            oLocked     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            frame_bad_q <= frame_bad_d;
            oPixValid   <= pix_vld_d;
            oFrameStart <= fs_d;
            oLineErr    <= line_err_d;
            oFrameErr   <= frame_err_d;
            if (pix_vld_d) begin
                oPixel <= color_s1;
                oPixX  <= cnt_q;
                oPixY  <= line_q;
            end
            if (lock_clr) begin
                oLocked <= 1'b0;
            end else if (lock_set) begin
                oLocked <= 1'b1;
            end
        end
    end

    // Line period is measured independently of the FSM; the first hs_end only starts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            lclk_q      <= '0;
            lclk_seen_q <= 1'b0;
            oLineClks   <= '0;
        end else if (hs_end) begin
            if (lclk_seen_q) begin
                oLineClks <= lclk_q;
            end
            lclk_seen_q <= 1'b1;
            lclk_q      <= 11'd1;
        end else if (lclk_q != LCLK_MAX) begin
            lclk_q <= 11'(lclk_q + 11'd1);
        end
    end

endmodule
